// File: rtl/clock_pkg.sv
// Shared constants, time record and load-validation helper for the BCD clock.
package clock_pkg;

    localparam logic [7:0] BCD_MAX_MS     = 8'h59;
    localparam logic [7:0] BCD_HR_MIN     = 8'h01;
    localparam logic [7:0] BCD_HR_MAX     = 8'h12;
    localparam logic [7:0] BCD_HR_PM_EDGE = 8'h11;

    // Default time after reset: 12:00:00 AM
    localparam logic [7:0] DEF_HH = 8'h12;
    localparam logic [7:0] DEF_MM = 8'h00;
    localparam logic [7:0] DEF_SS = 8'h00;
    localparam logic       DEF_PM = 1'b0;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
        logic       pm;
    } bcd_time_t;

    localparam bcd_time_t RESET_TIME = '{hh: DEF_HH, mm: DEF_MM, ss: DEF_SS, pm: DEF_PM};

    // Both digits must be decimal; a value with a hex digit never enters the counters.
    function automatic logic bcd_digits_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // A time is loadable when hours are 01..12 and minutes/seconds are 00..59.
    function automatic logic load_valid(input bcd_time_t t);
        logic ok;
        ok = bcd_digits_ok(t.hh) && bcd_digits_ok(t.mm) && bcd_digits_ok(t.ss);
        ok = ok && (t.hh >= BCD_HR_MIN) && (t.hh <= BCD_HR_MAX);
        ok = ok && (t.mm <= BCD_MAX_MS) && (t.ss <= BCD_MAX_MS);
        return ok;
    endfunction

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD 00..59 counter with load; carry flags the 59 -> 00 step.
module bcd_mod60
    import clock_pkg::*;
#(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       ld,
    input  logic [7:0] ld_val,
    output logic [7:0] q,
    output logic       carry
);

    logic [7:0] q_next;

    assign carry = en && (q == BCD_MAX_MS);

    // Next count: ones wrap at 9 into the tens digit, tens wrap at 5 back to 00.
    always_comb begin
        q_next = q;
        if (q[3:0] == 4'd9) begin
            if (q[7:4] == 4'd5) begin
                q_next = 8'h00;
            end else begin
                q_next = {q[7:4] + 4'd1, 4'd0};
            end
        end else begin
            q_next = {q[7:4], q[3:0] + 4'd1};
        end
    end

    // Count register; load wins over enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (ld) begin
            q <= ld_val;
        end else if (en) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/bcd_clock_hms.sv
// Twelve-hour BCD time-of-day counter driven by a 1 Hz tick, with checked time load.
module bcd_clock_hms
    import clock_pkg::*;
#(
    parameter logic [7:0] RESET_HH = DEF_HH,
    parameter logic [7:0] RESET_MM = DEF_MM,
    parameter logic [7:0] RESET_SS = DEF_SS,
    parameter logic       RESET_PM = DEF_PM
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       run,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    input  logic       load_pm,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       pm,
    output logic       load_err,
    output logic       day_pulse
);

    bcd_time_t  ld_t;
    logic       ld_ok;
    logic       adv;
    logic       sec_carry;
    logic       hr_step;
    logic [7:0] hh_next;

    assign ld_t    = '{hh: load_hh, mm: load_mm, ss: load_ss, pm: load_pm};
    assign ld_ok   = load && load_valid(ld_t);
    // A tick that coincides with a load request (accepted or not) is dropped.
    assign adv     = tick && run && !load;

    bcd_mod60 #(.RESET_VAL(RESET_SS)) u_sec (
        .clk    (clk),
        .reset  (reset),
        .en     (adv),
        .ld     (ld_ok),
        .ld_val (load_ss),
        .q      (ss),
        .carry  (sec_carry)
    );

    bcd_mod60 #(.RESET_VAL(RESET_MM)) u_min (
        .clk    (clk),
        .reset  (reset),
        .en     (sec_carry),
        .ld     (ld_ok),
        .ld_val (load_mm),
        .q      (mm),
        .carry  (hr_step)
    );

    // Hour sequence 12 -> 01 .. 09 -> 10 -> 11 -> 12; 12 -> 01 is a wrap, not a carry.
    always_comb begin
        hh_next = hh;
        if (hh == BCD_HR_MAX) begin
            hh_next = BCD_HR_MIN;
        end else if (hh[3:0] == 4'd9) begin
            hh_next = {hh[7:4] + 4'd1, 4'd0};
        end else begin
            hh_next = {hh[7:4], hh[3:0] + 4'd1};
        end
    end

    // Hour and AM/PM registers; PM flips only on the 11 -> 12 step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hh <= RESET_HH;
            pm <= RESET_PM;
        end else if (ld_ok) begin
            hh <= load_hh;
            pm <= load_pm;
        end else if (hr_step) begin
            hh <= hh_next;
            if (hh == BCD_HR_PM_EDGE) begin
                pm <= ~pm;
            end
        end
    end

    // Status pulses: rejected load, and the 11:59:59 PM -> 12:00:00 AM rollover.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_err  <= 1'b0;
            day_pulse <= 1'b0;
        end else begin
            load_err  <= load && !ld_ok;
            day_pulse <= hr_step && (hh == BCD_HR_PM_EDGE) && pm;
        end
    end

endmodule

// File: doc/bcd_clock_hms.md
# bcd_clock_hms

Twelve-hour BCD time-of-day counter that consumes the one-cycle `tick` enable produced by the upstream frequency divider. It keeps hours, minutes and seconds as packed two-digit BCD plus an AM/PM flag, and supports a synchronous time-load with validity checking. It sits between the divider and the display or multiplexing stage, which reads its registered outputs directly.

## Interface
- `RESET_HH`, default 8'h12: hours value after reset (BCD, 01..12)
- `RESET_MM`, default 8'h00: minutes value after reset (BCD, 00..59)
- `RESET_SS`, default 8'h00: seconds value after reset (BCD, 00..59)
- `RESET_PM`, default 1'b0: AM/PM flag after reset (0 = AM)
- `clk` input 1: single clock, rising edge
- `reset` input 1: asynchronous, active-high reset
- `tick` input 1: advance one second when high on a clock edge (1 Hz enable from divider)
- `run` input 1: when 0, `tick` is ignored
- `load` input 1: request to load the time
- `load_hh`, `load_mm`, `load_ss` input 8 each: packed BCD time to load
- `load_pm` input 1: PM flag to load
- `hh`, `mm`, `ss` output 8 each: packed BCD time, tens digit in [7:4]
- `pm` output 1: 1 = PM
- `load_err` output 1: one-cycle pulse, previous load rejected
- `day_pulse` output 1: one-cycle pulse on 11:59:59 PM -> 12:00:00 AM

## Operation
- Reset (asynchronous): `hh/mm/ss/pm` = RESET_* values; `load_err` = 0; `day_pulse` = 0.
- Advance condition: `adv = tick & run & ~load`.
- Seconds: on `adv`, ones 0..9 then wraps to 0 and carries to tens; tens 0..5. 59 -> 00 asserts `sec_carry`.
- Minutes: advance only when `adv & ss==59`. Same 00..59 rule, with carry out at 59.
- Hours: advance only when `adv & ss==59 & mm==59`. Sequence 12 -> 01 -> … -> 09 -> 10 -> 11 -> 12. The step 09 -> 10 needs a tens carry. The step 12 -> 01 is an explicit wrap, not a carry.
- PM: toggles exactly on the hour step 11 -> 12. It is unchanged on 12 -> 01.
- `day_pulse`: set for one cycle when the hour step 11 -> 12 takes `pm` from 1 to 0.
- Load handling:
  - A load is valid only if every nibble is ≤ 9, `load_hh` is 01..12, and `load_mm` and `load_ss` are 00..59.
  - Valid load: all four fields are replaced on the next edge and no carry chain runs.
  - Invalid load: time is unchanged and `load_err` = 1 for one cycle.
- Load has priority over tick. A tick coinciding with `load` is dropped, not deferred.
- `tick` held high for N cycles advances N seconds. No edge detection is done.
- A load of a value such as 11:59:59 PM is accepted. The next `adv` then rolls it over normally and asserts `day_pulse`.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Latency is 1 cycle for each of these:
  - tick at edge n: new value visible after edge n.
  - load at edge n: new value or `load_err` visible after edge n.
  - `day_pulse`: high during the cycle following the rollover edge.
- `load_err` and `day_pulse` are never high for two consecutive cycles unless the triggering condition repeats.
- Reset mid-count returns to the RESET_* values immediately, regardless of `clk`. Any pending pulse is cleared.
- No handshake back-pressure: `load` is accepted every cycle.

## Structure
- The shared package `clock_pkg` holds:
  - BCD constants: `BCD_MAX_MS` = 8'h59, `BCD_HR_MIN` = 8'h01, `BCD_HR_MAX` = 8'h12, `BCD_HR_PM_EDGE` = 8'h11.
  - The default reset time.
  - A `bcd_time_t` struct {hh, mm, ss, pm}.
- One sub-module is natural: `bcd_mod60`. It is a two-digit BCD 00..59 counter with `en`, load port and `carry` output, instantiated twice for seconds and minutes.
- The hour counter and PM logic stay inline, because their wrap rule is irregular.
- Load validation is a combinational function in `clock_pkg`.

## Test plan
- Reset: assert `reset` asynchronously between edges. Outputs read 12:00:00 AM immediately, `load_err` = 0, `day_pulse` = 0.
- Seconds/minutes carry: load 01:58:59 AM, then one tick. Result 01:59:00 AM; after 60 more ticks, 02:00:00 AM.
- AM/PM and hour wrap:
  - Load 11:59:59 AM, tick: 12:00:00 PM.
  - Load 12:59:59 PM, tick: 01:00:00 PM, `pm` still 1.
- Day rollover: load 11:59:59 PM, tick. Result 12:00:00 AM and `day_pulse` = 1 for exactly one cycle.
- Invalid load:
  - `load_hh` = 8'h13, or `load_mm` = 8'h5A, or `load_hh` = 8'h00: `load_err` pulses one cycle and time is unchanged.
  - `load` with `tick` in the same cycle, loading 03:04:05: result is 03:04:05, not 03:04:06.
- Run gating and held tick:
  - `run` = 0 with 10 ticks: no change.
  - `run` = 1 with `tick` held high 5 cycles from 00:00 seconds: `ss` = 05.
  - `reset` asserted at 07:30:45 mid-sequence: returns to 12:00:00 AM.
